rmii_tx_serializer: RTL and testbench

Transmit-side counterpart to the receive dibit reorderer. It accepts whole bytes on a valid/ready interface and serializes each byte onto the 2-bit RMII-style transmit bus, least-significant dibit first.
It automatically prepends preamble and SFD, enforces the inter-frame gap, and flags underruns. It sits between the frame builder (MAC/CRC stage) and the PHY TXEN/TXD pins.

---
 rtl/rmii_tx_pkg.sv | 22 ++
 rtl/rmii_tx_serializer.sv | 172 +++++++++++++++++
 tb/tb_rmii_tx_serializer.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rmii_tx_pkg.sv
// Shared types and constants for the RMII transmit serializer.
package rmii_tx_pkg;

    typedef enum logic [1:0] {IDLE, PRE, DATA, IFG} tx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] DEFAULT_SFD   = 8'hD5;

    function automatic logic [1:0] dibit_sel(input logic [7:0] b, input logic [1:0] idx);
        logic [1:0] d;
        d = b[1:0];
        case (idx)
            2'd0: d = b[1:0];
            2'd1: d = b[3:2];
            2'd2: d = b[5:4];
            2'd3: d = b[7:6];
            default: d = b[1:0];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rmii_tx_serializer.sv
// Byte-to-dibit RMII transmit serializer: adds preamble/SFD, enforces the
// inter-frame gap and reports underruns when the source runs dry mid-frame.
module rmii_tx_serializer
    import rmii_tx_pkg::*;
#(
    parameter int unsigned PREAMBLE_BYTES = 7,
    parameter logic [7:0]  SFD_BYTE       = DEFAULT_SFD,
    parameter int unsigned IFG_DIBITS     = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [7:0] axiid,
    input  logic       axiil,
    output logic       axiir,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       underrun
);

    localparam logic [7:0] PreLast = 8'(PREAMBLE_BYTES);
    localparam logic [5:0] IfgLast = 6'(IFG_DIBITS - 1);

    tx_state_t  state_q, state_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_last_q, hold_last_d;
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] shift_q, shift_d;
    logic       shift_last_q, shift_last_d;
    logic [1:0] dib_q, dib_d;
    logic [7:0] byte_q, byte_d;
    logic [5:0] ifg_q, ifg_d;
    logic       axiov_q, axiov_d;
    logic [1:0] axiod_q, axiod_d;
    logic       underrun_q, underrun_d;

    logic       accept;
    logic [7:0] pre_byte;

    // Once the frame's last byte sits in the shifter, the next frame waits for IFG.
    assign axiir  = rst & ~hold_valid_q & ~((state_q == DATA) & shift_last_q);
    assign accept = axiiv & axiir;

    assign axiov    = axiov_q;
    assign axiod    = axiod_q;
    assign underrun = underrun_q;

    always_comb begin
        state_d      = state_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        shift_last_d = shift_last_q;
        dib_d        = dib_q;
        byte_d       = byte_q;
        ifg_d        = ifg_q;
        underrun_d   = 1'b0;

        if (accept) begin
            hold_data_d  = axiid;
            hold_last_d  = axiil;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_valid_q) begin
                    state_d = PRE;
                    byte_d  = 8'd0;
                    dib_d   = 2'd0;
                end
            end
            PRE: begin
                dib_d = dib_q + 2'd1;
                if (dib_q == 2'd3) begin
                    if (byte_q == PreLast) begin
                        state_d      = DATA;
                        shift_d      = hold_data_q;
                        shift_last_d = hold_last_q;
                        hold_valid_d = 1'b0;
                    end else begin
                        byte_d = byte_q + 8'd1;
                    end
                end
            end
            DATA: begin
                dib_d = dib_q + 2'd1;
                if (dib_q == 2'd3) begin
                    if (shift_last_q) begin
                        state_d = IFG;
                        ifg_d   = 6'd0;
                    end else if (hold_valid_q) begin
                        shift_d      = hold_data_q;
                        shift_last_d = hold_last_q;
                        hold_valid_d = 1'b0;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = IFG;
                        ifg_d      = 6'd0;
                    end
                end
            end
            IFG: begin
                if (ifg_q == IfgLast) begin
                    if (hold_valid_q) begin
                        state_d = PRE;
                        byte_d  = 8'd0;
                        dib_d   = 2'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ifg_d = ifg_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next-state values.
    always_comb begin
        pre_byte = (byte_d == PreLast) ? SFD_BYTE : PREAMBLE_BYTE;
        axiov_d  = 1'b0;
        axiod_d  = 2'd0;
        case (state_d)
            PRE: begin
                axiov_d = 1'b1;
                axiod_d = dibit_sel(pre_byte, dib_d);
            end
            DATA: begin
                axiov_d = 1'b1;
                axiod_d = dibit_sel(shift_d, dib_d);
            end
            default: begin
                axiov_d = 1'b0;
                axiod_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            hold_data_q  <= 8'd0;
            hold_last_q  <= 1'b0;
            hold_valid_q <= 1'b0;
            shift_q      <= 8'd0;
            shift_last_q <= 1'b0;
            dib_q        <= 2'd0;
            byte_q       <= 8'd0;
            ifg_q        <= 6'd0;
            axiov_q      <= 1'b0;
            axiod_q      <= 2'd0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            shift_last_q <= shift_last_d;
            dib_q        <= dib_d;
            byte_q       <= byte_d;
            ifg_q        <= ifg_d;
            axiov_q      <= axiov_d;
            axiod_q      <= axiod_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_rmii_tx_serializer.sv
// Self-checking bench for rmii_tx_serializer: logs the bus every cycle and
// compares frames against a preamble/SFD/byte-stream reference model.
module tb_rmii_tx_serializer;

    localparam int P   = 7;
    localparam int IFG = 48;
    localparam int HDR = 4 * (P + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       axiiv = 1'b0;
    logic [7:0] axiid = 8'h00;
    logic       axiil = 1'b0;
    logic       axiir;
    logic       axiov;
    logic [1:0] axiod;
    logic       underrun;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic       lv[$];
    logic       lu[$];
    logic       lr[$];
    logic [1:0] ld[$];
    int         acc[$];
    logic [7:0] sd[$];
    logic       sl[$];
    int         fs[$];
    int         fl[$];
    logic [7:0] eb[$];
    logic       src_en = 1'b0;

    rmii_tx_serializer dut (
        .clk      (clk),
        .rst      (rst),
        .axiiv    (axiiv),
        .axiid    (axiid),
        .axiil    (axiil),
        .axiir    (axiir),
        .axiov    (axiov),
        .axiod    (axiod),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic drive();
        if (src_en && sd.size() > 0) begin
            axiiv = 1'b1;
            axiid = sd[0];
            axiil = sl[0];
        end else begin
            axiiv = 1'b0;
            axiid = 8'h00;
            axiil = 1'b0;
        end
    endtask

    task automatic tick();
        logic fire;
        @(negedge clk);
        lv.push_back(axiov);
        ld.push_back(axiod);
        lu.push_back(underrun);
        lr.push_back(axiir);
        fire = axiiv && axiir && rst;
        if (fire) acc.push_back(cyc);
        @(posedge clk);
        cyc++;
        #1;
        if (fire) begin
            void'(sd.pop_front());
            void'(sl.pop_front());
        end
        drive();
    endtask

    task automatic start_log();
        cyc = 0;
        lv.delete(); ld.delete(); lu.delete(); lr.delete(); acc.delete();
    endtask

    task automatic scan_frames();
        fs.delete();
        fl.delete();
        for (int i = 0; i < lv.size(); i++) begin
            if (lv[i] === 1'b1 && (i == 0 || lv[i-1] !== 1'b1)) begin
                fs.push_back(i);
                fl.push_back(0);
            end
            if (lv[i] === 1'b1) fl[fl.size()-1] = fl[fl.size()-1] + 1;
        end
    endtask

    // Reference: 0x55 preamble bytes, SFD, then payload, each byte LSB dibit first.
    function automatic logic [1:0] exp_dibit(int k, logic [7:0] b);
        logic [7:0] v;
        if (k < 4 * P) v = 8'h55;
        else if (k < HDR) v = 8'hD5;
        else v = b;
        return 2'((v >> (2 * (k % 4))) & 8'h03);
    endfunction

    function automatic int first_bad(int st);
        logic [7:0] b;
        int len;
        len = HDR + 4 * eb.size();
        for (int k = 0; k < len; k++) begin
            b = (k >= HDR) ? eb[(k - HDR) / 4] : 8'h00;
            if (st + k >= ld.size()) return k;
            if (ld[st + k] !== exp_dibit(k, b)) return k;
        end
        return -1;
    endfunction

    function automatic int count_ones(logic q[$], int lo, int hi);
        int n = 0;
        for (int i = lo; i <= hi && i < q.size(); i++) if (q[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic push_byte(logic [7:0] b, logic last);
        sd.push_back(b);
        sl.push_back(last);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        src_en = 1'b0;
        drive();
        start_log();
        repeat (3) tick();
        n_tests++; if (lv[2] !== 1'b0) begin n_fail++; $display("FAIL reset_axiov: got %b want 0", lv[2]); end
        n_tests++; if (ld[2] !== 2'b00) begin n_fail++; $display("FAIL reset_axiod: got %b want 00", ld[2]); end
        n_tests++; if (lu[2] !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", lu[2]); end
        n_tests++; if (lr[2] !== 1'b0) begin n_fail++; $display("FAIL reset_axiir: got %b want 0", lr[2]); end
        rst = 1'b1;
        tick();
        n_tests++; if (lr[3] !== 1'b1) begin n_fail++; $display("FAIL reset_release_axiir: got %b want 1", lr[3]); end
    endtask

    task automatic test_single_byte();
        int bad;
        start_log();
        src_en = 1'b1;
        push_byte(8'hA5, 1'b1);
        drive();
        repeat (130) tick();
        scan_frames();
        eb.delete(); eb.push_back(8'hA5);
        n_tests++; if (fs.size() !== 1 || acc.size() !== 1) begin
            n_fail++; $display("FAIL single_count: got %0d frames %0d accepts want 1 1", fs.size(), acc.size());
        end else begin
            n_tests++; if (fs[0] !== acc[0] + 2) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", fs[0], acc[0] + 2); end
            n_tests++; if (fl[0] !== 36) begin n_fail++; $display("FAIL single_len: got %0d want 36", fl[0]); end
            bad = first_bad(fs[0]);
            n_tests++; if (bad !== -1) begin n_fail++; $display("FAIL single_dibits: first bad index %0d want none", bad); end
            n_tests++; if (count_ones(lv, fs[0] + 36, fs[0] + 36 + IFG - 1) !== 0) begin
                n_fail++; $display("FAIL single_ifg: axiov high during gap, want 0");
            end
        end
        n_tests++; if (count_ones(lu, 0, lu.size() - 1) !== 0) begin n_fail++; $display("FAIL single_underrun: got pulses want 0"); end
    endtask

    task automatic test_back_to_back();
        int bad;
        start_log();
        push_byte(8'h00, 1'b0); push_byte(8'hFF, 1'b0); push_byte(8'h1B, 1'b1);
        drive();
        repeat (130) tick();
        scan_frames();
        eb.delete(); eb.push_back(8'h00); eb.push_back(8'hFF); eb.push_back(8'h1B);
        n_tests++; if (fs.size() !== 1 || acc.size() !== 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d frames %0d accepts want 1 3", fs.size(), acc.size());
        end else begin
            n_tests++; if (fl[0] !== HDR + 12) begin n_fail++; $display("FAIL b2b_len: got %0d want %0d", fl[0], HDR + 12); end
            bad = first_bad(fs[0]);
            n_tests++; if (bad !== -1) begin n_fail++; $display("FAIL b2b_dibits: first bad index %0d want none", bad); end
            n_tests++; if (acc[1] - acc[0] !== 34) begin n_fail++; $display("FAIL b2b_accept1: got %0d want 34", acc[1] - acc[0]); end
            n_tests++; if (acc[2] - acc[1] !== 4) begin n_fail++; $display("FAIL b2b_accept2: got %0d want 4", acc[2] - acc[1]); end
            n_tests++; if (count_ones(lr, acc[0], acc[2]) !== 3) begin
                n_fail++; $display("FAIL b2b_ready_pulses: got %0d want 3", count_ones(lr, acc[0], acc[2]));
            end
        end
    endtask

    task automatic test_ifg_second_frame();
        logic [7:0] b0, b1;
        int bad;
        b0 = 8'($urandom); b1 = 8'($urandom);
        start_log();
        push_byte(b0, 1'b1); push_byte(b1, 1'b1);
        drive();
        repeat (200) tick();
        scan_frames();
        n_tests++; if (fs.size() !== 2 || acc.size() !== 2) begin
            n_fail++; $display("FAIL ifg_count: got %0d frames %0d accepts want 2 2", fs.size(), acc.size());
        end else begin
            n_tests++; if (acc[1] < fs[0] + fl[0] || acc[1] >= fs[0] + fl[0] + IFG) begin
                n_fail++; $display("FAIL ifg_accept: got cycle %0d want within IFG from %0d", acc[1], fs[0] + fl[0]);
            end
            n_tests++; if (fs[1] - (fs[0] + fl[0]) !== IFG) begin
                n_fail++; $display("FAIL ifg_gap: got %0d want %0d", fs[1] - (fs[0] + fl[0]), IFG);
            end
            eb.delete(); eb.push_back(b1);
            bad = first_bad(fs[1]);
            n_tests++; if (bad !== -1) begin n_fail++; $display("FAIL ifg_dibits: first bad index %0d want none", bad); end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] b0, b1;
        int bad, upos, ucnt;
        b0 = 8'($urandom); b1 = 8'($urandom);
        start_log();
        push_byte(b0, 1'b0);
        drive();
        repeat (80) tick();
        push_byte(b1, 1'b1);
        drive();
        repeat (100) tick();
        scan_frames();
        upos = -1; ucnt = 0;
        for (int i = 0; i < lu.size(); i++) if (lu[i] === 1'b1) begin ucnt++; upos = i; end
        n_tests++; if (ucnt !== 1) begin n_fail++; $display("FAIL underrun_count: got %0d want 1", ucnt); end
        n_tests++; if (fs.size() !== 2) begin
            n_fail++; $display("FAIL underrun_frames: got %0d want 2", fs.size());
        end else begin
            n_tests++; if (upos !== fs[0] + 36) begin n_fail++; $display("FAIL underrun_pos: got %0d want %0d", upos, fs[0] + 36); end
            n_tests++; if (fl[0] !== 36) begin n_fail++; $display("FAIL underrun_len: got %0d want 36", fl[0]); end
            eb.delete(); eb.push_back(b0);
            bad = first_bad(fs[0]);
            n_tests++; if (bad !== -1) begin n_fail++; $display("FAIL underrun_dibits0: first bad index %0d want none", bad); end
            n_tests++; if (fs[1] !== fs[0] + 36 + IFG) begin n_fail++; $display("FAIL underrun_restart: got %0d want %0d", fs[1], fs[0] + 36 + IFG); end
            eb.delete(); eb.push_back(b1);
            bad = first_bad(fs[1]);
            n_tests++; if (bad !== -1) begin n_fail++; $display("FAIL underrun_dibits1: first bad index %0d want none", bad); end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        start_log();
        eb.delete();
        for (int i = 0; i < 4; i++) begin
            eb.push_back(8'($urandom));
            push_byte(eb[i], i == 3);
        end
        drive();
        repeat (140) tick();
        scan_frames();
        n_tests++; if (acc.size() !== 4 || fs.size() !== 1) begin
            n_fail++; $display("FAIL bp_count: got %0d accepts %0d frames want 4 1", acc.size(), fs.size());
        end else begin
            n_tests++; if (count_ones(lr, acc[0] + 1, acc[0] + 33) !== 0) begin
                n_fail++; $display("FAIL bp_ready_low: got %0d high cycles want 0", count_ones(lr, acc[0] + 1, acc[0] + 33));
            end
            n_tests++; if (lr[acc[0] + 34] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_sfd: got %b want 1", lr[acc[0] + 34]); end
            n_tests++; if (fl[0] !== HDR + 16) begin n_fail++; $display("FAIL bp_len: got %0d want %0d", fl[0], HDR + 16); end
            bad = first_bad(fs[0]);
            n_tests++; if (bad !== -1) begin n_fail++; $display("FAIL bp_dibits: first bad index %0d want none", bad); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int bad, a0;
        start_log();
        for (int i = 0; i < 3; i++) push_byte(8'($urandom), i == 2);
        drive();
        repeat (40) tick();
        rst = 1'b0;
        tick();
        tick();
        n_tests++; if (lv[41] !== 1'b0) begin n_fail++; $display("FAIL rstmid_axiov: got %b want 0", lv[41]); end
        n_tests++; if (ld[41] !== 2'b00) begin n_fail++; $display("FAIL rstmid_axiod: got %b want 00", ld[41]); end
        n_tests++; if (lr[41] !== 1'b0) begin n_fail++; $display("FAIL rstmid_axiir: got %b want 0", lr[41]); end
        sd.delete(); sl.delete();
        a0 = acc.size();
        rst = 1'b1;
        b = 8'($urandom);
        push_byte(b, 1'b1);
        drive();
        repeat (60) tick();
        scan_frames();
        n_tests++; if (fs.size() !== 2 || acc.size() !== a0 + 1) begin
            n_fail++; $display("FAIL rstmid_frames: got %0d frames %0d new accepts want 2 1", fs.size(), acc.size() - a0);
        end else begin
            n_tests++; if (acc[a0] !== 42) begin n_fail++; $display("FAIL rstmid_accept: got %0d want 42", acc[a0]); end
            n_tests++; if (fs[1] !== acc[a0] + 2) begin n_fail++; $display("FAIL rstmid_restart: got %0d want %0d", fs[1], acc[a0] + 2); end
            eb.delete(); eb.push_back(b);
            bad = first_bad(fs[1]);
            n_tests++; if (bad !== -1) begin n_fail++; $display("FAIL rstmid_dibits: first bad index %0d want none", bad); end
        end
        repeat (60) tick();
    endtask

    task automatic test_random();
        int nb[4];
        logic [7:0] fb[4][$];
        int exp_start, bad, total;
        start_log();
        total = 0;
        for (int f = 0; f < 4; f++) begin
            nb[f] = $urandom_range(1, 4);
            for (int i = 0; i < nb[f]; i++) begin
                fb[f].push_back(8'($urandom));
                push_byte(fb[f][i], i == nb[f] - 1);
            end
            total += HDR + 4 * nb[f] + IFG;
        end
        drive();
        repeat (total + 20) tick();
        scan_frames();
        n_tests++; if (fs.size() !== 4 || acc.size() < 1) begin
            n_fail++; $display("FAIL rand_frames: got %0d want 4", fs.size());
        end else begin
            exp_start = acc[0] + 2;
            for (int f = 0; f < 4; f++) begin
                n_tests++; if (fs[f] !== exp_start) begin n_fail++; $display("FAIL rand_start%0d: got %0d want %0d", f, fs[f], exp_start); end
                n_tests++; if (fl[f] !== HDR + 4 * nb[f]) begin n_fail++; $display("FAIL rand_len%0d: got %0d want %0d", f, fl[f], HDR + 4 * nb[f]); end
                eb = fb[f];
                bad = first_bad(fs[f]);
                n_tests++; if (bad !== -1) begin n_fail++; $display("FAIL rand_dibits%0d: first bad index %0d want none", f, bad); end
                exp_start = exp_start + HDR + 4 * nb[f] + IFG;
            end
        end
        n_tests++; if (count_ones(lu, 0, lu.size() - 1) !== 0) begin n_fail++; $display("FAIL rand_underrun: got pulses want 0"); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_ifg_second_frame();
        test_underrun();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
